// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the reg_file_sb register file
// and its write scoreboard.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;

  // Register 0 is hardwired to zero and never tracked as busy.
  localparam int ZERO_REG = 0;

  // Scoreboard vector at the default depth; bit i = register i pending.
  typedef logic [DEF_NREGS-1:0] busy_vec_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: one busy flop per register. Issue reserves a
// destination, writeback releases it. A same-register set and clear in one
// cycle leaves the bit set. Register 0 is never busy.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   IssueEnb,
  input  logic [ADDR_W-1:0]      IssueReg,
  input  logic                   WriteEnb,
  input  logic [ADDR_W-1:0]      WriteReg,
  output logic                   IssueStall,
  output logic [(2**ADDR_W)-1:0] BusyVec
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [(2**ADDR_W)-1:0] busy_q;
  logic [(2**ADDR_W)-1:0] busy_d;
  logic                   issue_set;

  // Stall only on the registered bit; a writeback in the same cycle does not unstall.
  always_comb begin
    IssueStall = IssueEnb && (IssueReg != ZERO_ADDR) && busy_q[IssueReg];
    issue_set  = IssueEnb && (IssueReg != ZERO_ADDR) && !busy_q[IssueReg];
  end

  // Next busy state: clear first so a same-register set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (WriteEnb) begin
      busy_d[WriteReg] = 1'b0;
    end
    if (issue_set) begin
      busy_d[IssueReg] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy flops; reset drops every in-flight reservation.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign BusyVec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file (2 combinational reads, 1 write,
// register 0 hardwired to zero) with an integrated write scoreboard.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle writeback data to
// the read ports and masks their busy flags.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic [ADDR_W-1:0]      ReadReg1,
  input  logic [ADDR_W-1:0]      ReadReg2,
  output logic [DATA_W-1:0]      ReadData1,
  output logic [DATA_W-1:0]      ReadData2,
  output logic                   Busy1,
  output logic                   Busy2,
  input  logic                   WriteEnb,
  input  logic [ADDR_W-1:0]      WriteReg,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic                   IssueEnb,
  input  logic [ADDR_W-1:0]      IssueReg,
  output logic                   IssueStall,
  output logic [(2**ADDR_W)-1:0] BusyVec
);

  localparam int                NREGS     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;

  assign wr_en = WriteEnb && (WriteReg != ZERO_ADDR);

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .Clk        (Clk),
    .RstN       (RstN),
    .IssueEnb   (IssueEnb),
    .IssueReg   (IssueReg),
    .WriteEnb   (WriteEnb),
    .WriteReg   (WriteReg),
    .IssueStall (IssueStall),
    .BusyVec    (BusyVec)
  );

  // Next data array: writes to register 0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteReg] = WriteData;
    end
    regs_d[ZERO_REG] = '0;
  end

  // Data array; reset clears every register.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight writeback.
  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    ReadData2 = regs_q[ReadReg2];
    Busy1     = BusyVec[ReadReg1];
    Busy2     = BusyVec[ReadReg2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
      Busy1     = 1'b0;
    end
    if (wr_en && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
      Busy2     = 1'b0;
    end
`endif
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated write scoreboard, the successor to the fixed 32×32 register file in the MIPS single-cycle datapath. It provides two combinational read ports, one synchronous write port, a hardwired-zero register 0, optional write-to-read bypass, and per-register busy tracking. Busy tracking lets a multicycle or pipelined ALU stage reserve a destination at issue and release it at writeback. It sits between instruction decode/issue and the ALU/writeback MUX.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth NREGS = 2**ADDR_W
- Clk  in  1  rising-edge clock
- RstN  in  1  asynchronous, active-low reset
- ReadReg1, ReadReg2  in  ADDR_W  read addresses
- ReadData1, ReadData2  out  DATA_W  read data, combinational
- Busy1, Busy2  out  1  addressed register has a pending write
- WriteEnb  in  1  writeback strobe
- WriteReg  in  ADDR_W  writeback address
- WriteData  in  DATA_W  writeback data
- IssueEnb  in  1  request to reserve IssueReg as a destination
- IssueReg  in  ADDR_W  destination being reserved
- IssueStall  out  1  reservation refused this cycle
- BusyVec  out  NREGS  full scoreboard, bit i = register i pending

## Operation
- Reset, asserted asynchronously:
  - all registers go to 0
  - all busy bits go to 0
  - consequently ReadData* = 0, Busy* = 0, IssueStall = 0, BusyVec = 0
- Read: ReadDataN = reg[ReadRegN]. Register 0 always reads 0.
- Write: on the Clk rising edge with WriteEnb=1 and WriteReg≠0, reg[WriteReg] ← WriteData. A write to register 0 is discarded.
- Scoreboard, evaluated each edge:
  - Set: busy[IssueReg] is set when IssueEnb=1, IssueStall=0 and IssueReg≠0.
  - Clear: busy[WriteReg] is cleared when WriteEnb=1. Clearing a non-busy register is legal and has no effect.
  - Set and clear to the same register in the same cycle: the set wins, so the bit ends 1.
  - Set and clear to different registers: both take effect.
- IssueStall = IssueEnb & (IssueReg≠0) & busy[IssueReg]. It uses the registered busy value only; a same-cycle writeback clear does not unstall.
- IssueReg = 0 never stalls and never sets a bit.
- BusyN = busy[ReadRegN]. Bit 0 is constant 0.

## Timing
- Read latency is 0 cycles (combinational from address).
- Write data and busy updates become visible at the output on the cycle after the edge.
- IssueStall is combinational from IssueEnb/IssueReg and registered state.
- A reservation is observable through Busy*/BusyVec 1 cycle after issue.
- Reset asserted between edges: state clears immediately, and in-flight reservations are lost. The first edge after RstN rises behaves normally.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - When WriteEnb=1, WriteReg≠0 and WriteReg=ReadRegN, ReadDataN = WriteData in the same cycle and BusyN = 0 in the same cycle.
  - Register 0 is never bypassed.
- Undefined:
  - ReadDataN shows the old register value until after the edge.
  - BusyN stays 1 until after the edge.

## Structure
- Package reg_file_pkg holds:
  - default DATA_W/ADDR_W localparams
  - ZERO_REG address constant (0)
  - typedef for the busy vector
- Sub-module reg_file_scoreboard owns the NREGS busy flops, the set/clear priority, IssueStall, and BusyVec.
- The top level owns the data array, read muxes, and bypass logic.

## Test plan
1. Reset then read → reset RstN=0 mid-run, read regs 0, 5, 31 → ReadData* = 0, BusyVec = 0.
2. Write then read → write 0x12345678 to reg 2, next cycle read regs 2 and 0 → 0x12345678 and 0. Write 0xFFFFFFFF to reg 0 → still reads 0.
3. Issue/writeback cycle:
   - issue reg 3 → next cycle Busy1 = 1 (ReadReg1 = 3) and BusyVec[3] = 1
   - re-issue reg 3 → IssueStall = 1 and the bit is unchanged
   - write reg 3 with 0xA5A5A5A5 → next cycle busy clear and data correct
4. Simultaneous events:
   - busy reg 4 written and re-issued in the same cycle → IssueStall = 1, bit clears
   - non-busy reg 6 written and issued in the same cycle → bit ends 1
5. Bypass (REG_FILE_BYPASS_EN): WriteEnb with reg 7 = 0xDEADBEEF and ReadReg2 = 7 → ReadData2 = 0xDEADBEEF and Busy2 = 0 in the same cycle. Without the macro → old value and Busy2 = 1 until the edge.
6. Parametrisation: DATA_W=16, ADDR_W=3 → write 0xBEEF to reg 7, read back 0xBEEF, BusyVec width is 8.
